// File: rtl/black_bean_core_pkg.sv
// -----------------------------------------------------------------------------
// black_bean_core_pkg
// Shared definitions for the black_bean 8-bit accumulator/register CPU:
// datapath width, register-index width, opcode encoding, FSM state encoding
// and a helper that tells whether an opcode carries a second (operand) byte.
//
// Optional feature macro: BLACK_BEAN_HALT_EN
//   defined   -> the HALT state exists and opcode F stops the core
//   undefined -> no HALT state; opcode F is a one-byte NOP
// -----------------------------------------------------------------------------
package black_bean_core_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int REG_IDX_W  = 2;
   localparam int NUM_REGS   = 1 << REG_IDX_W;

   // Every 4-bit value is named so a cast from the instruction byte is always legal.
   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_LD   = 4'h2,
      OP_ST   = 4'h3,
      OP_MOV  = 4'h4,
      OP_ADD  = 4'h5,
      OP_SUB  = 4'h6,
      OP_AND  = 4'h7,
      OP_OR   = 4'h8,
      OP_XOR  = 4'h9,
      OP_NOT  = 4'hA,
      OP_JMP  = 4'hB,
      OP_JZ   = 4'hC,
      OP_JC   = 4'hD,
      OP_RSVD = 4'hE,
      OP_HALT = 4'hF
   } op_e;

`ifdef BLACK_BEAN_HALT_EN
   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_OPERAND = 2'd1,
      ST_EXEC    = 2'd2,
      ST_HALT    = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_OPERAND = 2'd1,
      ST_EXEC    = 2'd2
   } state_e;
`endif

   // Ops whose second byte is an immediate or an address.
   function automatic logic is_two_byte(input op_e op);
      return (op inside {OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC});
   endfunction

endpackage

// File: rtl/black_bean_core_if.sv
// -----------------------------------------------------------------------------
// black_bean_core_if
// Unified memory port shared by instruction fetch and data load/store.
//   IO_MEM_R_DATA  memory -> core, combinational read of IO_MEM_ADDR
//   IO_MEM_W_DATA  core -> memory, store data
//   IO_MEM_ADDR    core -> memory, address
//   IO_MEM_R_EN    core -> memory, read-sample indication (informational)
//   IO_MEM_W_EN    core -> memory, one-cycle write strobe per store
// Modports: master (core side), slave (memory side).
// -----------------------------------------------------------------------------
interface black_bean_core_if;
   import black_bean_core_pkg::*;

   logic [DATA_WIDTH-1:0] IO_MEM_R_DATA;
   logic [DATA_WIDTH-1:0] IO_MEM_W_DATA;
   logic [DATA_WIDTH-1:0] IO_MEM_ADDR;
   logic                  IO_MEM_R_EN;
   logic                  IO_MEM_W_EN;

   modport master (
      input  IO_MEM_R_DATA,
      output IO_MEM_W_DATA,
      output IO_MEM_ADDR,
      output IO_MEM_R_EN,
      output IO_MEM_W_EN
   );

   modport slave (
      output IO_MEM_R_DATA,
      input  IO_MEM_W_DATA,
      input  IO_MEM_ADDR,
      input  IO_MEM_R_EN,
      input  IO_MEM_W_EN
   );

endinterface

// File: rtl/black_bean_core_alu.sv
// -----------------------------------------------------------------------------
// black_bean_alu
// Purely combinational ALU for the register-register ops MOV..NOT.
//   op     in   opcode (only 4..A are meaningful here)
//   a      in   rd operand
//   b      in   rs operand
//   result out  value written back to rd
//   carry  out  ADD carry-out / SUB borrow, 0 for the logic ops
//   zero   out  result == 0
// -----------------------------------------------------------------------------
module black_bean_alu
   import black_bean_core_pkg::*;
(
   input  op_e                   op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  carry,
   output logic                  zero
);

   // One extra bit on ADD/SUB captures carry-out, and for subtraction that
   // top bit is set exactly when a < b, i.e. it is the borrow.
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_MOV:  result = b;
         OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/black_bean_core.sv
// -----------------------------------------------------------------------------
// black_bean_core
// Multi-cycle 8-bit register CPU: FETCH -> [OPERAND] -> EXEC -> FETCH.
// One-byte ops take 2 cycles, two-byte ops 3 cycles.
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   mem_bus   master modport of black_bean_core_if (unified memory port)
//   o_halted  out  core stopped (always 0 when HALT is not built)
// Parameters: DATA_WIDTH (8), RESET_PC (8'h00).
// Optional feature macro: BLACK_BEAN_HALT_EN (opcode F halts the core).
// -----------------------------------------------------------------------------
module black_bean_core #(
   parameter int                                 DATA_WIDTH = black_bean_core_pkg::DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0]              RESET_PC   = '0
) (
   input  logic               clk,
   input  logic               rst,
   black_bean_core_if.master  mem_bus,
   output logic               o_halted
);
   import black_bean_core_pkg::*;

   state_e                state_q;
   state_e                state_d;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] ir_q;
   logic [DATA_WIDTH-1:0] opr_q;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic                  z_q;
   logic                  c_q;

   op_e                   cur_op;
   op_e                   fetch_op;
   logic [REG_IDX_W-1:0]  rd_idx;
   logic [REG_IDX_W-1:0]  rs_idx;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_carry;
   logic                  alu_zero;

   assign cur_op   = op_e'(ir_q[7:4]);
   assign fetch_op = op_e'(mem_bus.IO_MEM_R_DATA[7:4]);
   assign rd_idx   = ir_q[3:2];
   assign rs_idx   = ir_q[1:0];

   black_bean_alu u_alu (
      .op     (cur_op),
      .a      (regs_q[rd_idx]),
      .b      (regs_q[rs_idx]),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   // State register; reset drops straight into FETCH so the first fetch from
   // RESET_PC happens in the cycle after reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. In FETCH the opcode is still on the read bus, not yet
   // in IR, so the one/two-byte decision looks at the incoming byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:   state_d = is_two_byte(fetch_op) ? ST_OPERAND : ST_EXEC;
         ST_OPERAND: state_d = ST_EXEC;
         ST_EXEC: begin
`ifdef BLACK_BEAN_HALT_EN
            state_d = (cur_op == OP_HALT) ? ST_HALT : ST_FETCH;
`else
            state_d = ST_FETCH;
`endif
         end
`ifdef BLACK_BEAN_HALT_EN
         ST_HALT:    state_d = ST_HALT;
`endif
         default:    state_d = ST_FETCH;
      endcase
   end

   // Memory port and status outputs, purely from state and registers. The
   // default address is PC, which also gives RESET_PC on the bus while reset
   // is held. Only EXEC of LD/ST redirects the address to the operand byte.
   always_comb begin
      mem_bus.IO_MEM_ADDR   = pc_q;
      mem_bus.IO_MEM_W_DATA = '0;
      mem_bus.IO_MEM_R_EN   = 1'b0;
      mem_bus.IO_MEM_W_EN   = 1'b0;
      o_halted              = 1'b0;
      case (state_q)
         ST_FETCH, ST_OPERAND: mem_bus.IO_MEM_R_EN = 1'b1;
         ST_EXEC: begin
            if (cur_op == OP_LD) begin
               mem_bus.IO_MEM_ADDR = opr_q;
               mem_bus.IO_MEM_R_EN = 1'b1;
            end else if (cur_op == OP_ST) begin
               mem_bus.IO_MEM_ADDR   = opr_q;
               mem_bus.IO_MEM_W_DATA = regs_q[rd_idx];
               mem_bus.IO_MEM_W_EN   = 1'b1;
            end
         end
`ifdef BLACK_BEAN_HALT_EN
         ST_HALT: o_halted = 1'b1;
`endif
         default: ;
      endcase
   end

   // Architectural state updates. PC wraps naturally at 8 bits, so an operand
   // sitting at 0x00 after an opcode at 0xFF needs no special handling.
   // MOV writes rd but leaves flags alone; ops 5..A update both Z and C.
   // Branches only reload PC, which already points past the operand byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         ir_q   <= '0;
         opr_q  <= '0;
         z_q    <= 1'b0;
         c_q    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_FETCH: begin
               ir_q <= mem_bus.IO_MEM_R_DATA;
               pc_q <= pc_q + 1'b1;
            end
            ST_OPERAND: begin
               opr_q <= mem_bus.IO_MEM_R_DATA;
               pc_q  <= pc_q + 1'b1;
            end
            ST_EXEC: begin
               case (cur_op)
                  OP_LDI: regs_q[rd_idx] <= opr_q;
                  OP_LD:  regs_q[rd_idx] <= mem_bus.IO_MEM_R_DATA;
                  OP_MOV: regs_q[rd_idx] <= alu_result;
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                     regs_q[rd_idx] <= alu_result;
                     z_q            <= alu_zero;
                     c_q            <= alu_carry;
                  end
                  OP_JMP: pc_q <= opr_q;
                  OP_JZ:  if (z_q) pc_q <= opr_q;
                  OP_JC:  if (c_q) pc_q <= opr_q;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_black_bean_core.sv
// -----------------------------------------------------------------------------
// tb_black_bean_core
// Directed programs for black_bean_core with a behavioural unified memory
// (combinational read, write on rising edge). Cycle numbers in comments count
// from 1 = the first cycle after reset is released (the first fetch).
// -----------------------------------------------------------------------------
module tb_black_bean_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       halted;
   logic [7:0] mem [256];
   logic       load_en   = 1'b0;
   logic [7:0] load_addr = 8'h00;
   logic [7:0] load_data = 8'h00;
   int         wr_cnt    = 0;
   int         rd_cnt    = 0;
   logic [7:0] wr_addr   = 8'h00;
   int         total     = 0;
   int         bad       = 0;
   int         wr_base;
   int         rd_base;
   logic [7:0] halt_addr;

   black_bean_core_if mem_if ();

   black_bean_core #(
      .DATA_WIDTH (8),
      .RESET_PC   (8'h00)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_bus  (mem_if),
      .o_halted (halted)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, DUT stores take priority over the
   // bench's own program-loading port.
   assign mem_if.IO_MEM_R_DATA = mem[mem_if.IO_MEM_ADDR];

   always @(posedge clk) begin
      if (mem_if.IO_MEM_W_EN) begin
         mem[mem_if.IO_MEM_ADDR] <= mem_if.IO_MEM_W_DATA;
      end else if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   // Bus activity counters used to check store pulses and a quiet halted core.
   always @(posedge clk) begin
      if (!rst) begin
         if (mem_if.IO_MEM_W_EN) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_if.IO_MEM_ADDR;
         end
         if (mem_if.IO_MEM_R_EN) begin
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic loadByte(input logic [7:0] a, input logic [7:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   // Assert reset and wipe memory to zeros (NOP) before the next program.
   task automatic startProgram();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 256; i++) loadByte(8'(i), 8'h00);
   endtask

   // Release reset on a falling edge and settle just after it.
   task automatic releaseReset();
      rst = 1'b0;
      #1;
      wr_base = wr_cnt;
      rd_base = rd_cnt;
   endtask

   initial begin
      // ---------------- Reset and first fetch; LDI/ADD/ST, JZ/JC taken ------
      startProgram();
      loadByte(8'h00, 8'h10); loadByte(8'h01, 8'h05);   // LDI R0,05
      loadByte(8'h02, 8'h14); loadByte(8'h03, 8'hFB);   // LDI R1,FB
      loadByte(8'h04, 8'h51);                           // ADD R0,R1
      loadByte(8'h05, 8'h30); loadByte(8'h06, 8'h80);   // ST R0,80
      loadByte(8'h07, 8'hC0); loadByte(8'h08, 8'h20);   // JZ 20
      loadByte(8'h20, 8'hD0); loadByte(8'h21, 8'h30);   // JC 30
      loadByte(8'h80, 8'hAA);
      checkOutput("rst_addr", 32'(mem_if.IO_MEM_ADDR), 32'h00);
      checkOutput("rst_wen", 32'(mem_if.IO_MEM_W_EN), 32'h0);
      checkOutput("rst_ren", 32'(mem_if.IO_MEM_R_EN), 32'h1);
      checkOutput("rst_wdata", 32'(mem_if.IO_MEM_W_DATA), 32'h00);
      checkOutput("rst_halted", 32'(halted), 32'h0);
      releaseReset();
      checkOutput("first_fetch_addr", 32'(mem_if.IO_MEM_ADDR), 32'h00);
      checkOutput("first_fetch_ren", 32'(mem_if.IO_MEM_R_EN), 32'h1);
      applyStimulus(1);                                  // cycle 2: operand
      checkOutput("ldi_operand_addr", 32'(mem_if.IO_MEM_ADDR), 32'h01);
      applyStimulus(9);                                  // cycle 11: ST exec
      checkOutput("st_addr", 32'(mem_if.IO_MEM_ADDR), 32'h80);
      checkOutput("st_wen", 32'(mem_if.IO_MEM_W_EN), 32'h1);
      checkOutput("st_wdata", 32'(mem_if.IO_MEM_W_DATA), 32'h00);
      applyStimulus(7);                                  // cycle 18
      checkOutput("jz_jc_taken_fetch", 32'(mem_if.IO_MEM_ADDR), 32'h30);
      checkOutput("add_store_mem80", 32'(mem[8'h80]), 32'h00);
      checkOutput("one_store_pulse", 32'(wr_cnt - wr_base), 32'd1);
      checkOutput("store_pulse_addr", 32'(wr_addr), 32'h80);

      // ---------------- LD / SUB borrow, JC taken, JZ not taken -------------
      startProgram();
      loadByte(8'h00, 8'h28); loadByte(8'h01, 8'h90);   // LD R2,90
      loadByte(8'h02, 8'h1C); loadByte(8'h03, 8'h04);   // LDI R3,04
      loadByte(8'h04, 8'h6B);                           // SUB R2,R3
      loadByte(8'h05, 8'h38); loadByte(8'h06, 8'h91);   // ST R2,91
      loadByte(8'h07, 8'hD0); loadByte(8'h08, 8'h40);   // JC 40
      loadByte(8'h40, 8'hC0); loadByte(8'h41, 8'h50);   // JZ 50
      loadByte(8'h90, 8'h03);
      releaseReset();
      applyStimulus(2);                                  // cycle 3: LD exec
      checkOutput("ld_addr", 32'(mem_if.IO_MEM_ADDR), 32'h90);
      checkOutput("ld_ren", 32'(mem_if.IO_MEM_R_EN), 32'h1);
      applyStimulus(15);                                 // cycle 18
      checkOutput("jz_not_taken_fetch", 32'(mem_if.IO_MEM_ADDR), 32'h42);
      checkOutput("sub_borrow_mem91", 32'(mem[8'h91]), 32'hFF);

      // ---------------- XOR -> Z, JZ taken, JMP -----------------------------
      startProgram();
      loadByte(8'h00, 8'h10); loadByte(8'h01, 8'h33);   // LDI R0,33
      loadByte(8'h02, 8'h90);                           // XOR R0,R0
      loadByte(8'h03, 8'hC0); loadByte(8'h04, 8'h60);   // JZ 60
      loadByte(8'h60, 8'hB0); loadByte(8'h61, 8'h10);   // JMP 10
      loadByte(8'h10, 8'h30); loadByte(8'h11, 8'h81);   // ST R0,81
      loadByte(8'h81, 8'hAA);
      releaseReset();
      applyStimulus(3);                                  // cycle 4: XOR fetch
      checkOutput("xor_fetch_addr", 32'(mem_if.IO_MEM_ADDR), 32'h02);
      applyStimulus(1);                                  // cycle 5: XOR exec
      checkOutput("one_byte_exec_ren", 32'(mem_if.IO_MEM_R_EN), 32'h0);
      applyStimulus(3);                                  // cycle 8: JZ exec
      applyStimulus(1);                                  // cycle 9
      checkOutput("jz_taken_fetch", 32'(mem_if.IO_MEM_ADDR), 32'h60);
      applyStimulus(3);                                  // cycle 12
      checkOutput("jmp_fetch", 32'(mem_if.IO_MEM_ADDR), 32'h10);
      applyStimulus(3);                                  // cycle 15
      checkOutput("xor_zero_mem81", 32'(mem[8'h81]), 32'h00);

      // ---------------- PC wrap with operand at 0x00 ------------------------
      startProgram();
      loadByte(8'h00, 8'h42);                           // MOV R0,R2 / LDI imm
      loadByte(8'h01, 8'h30); loadByte(8'h02, 8'h85);   // ST R0,85
      loadByte(8'h03, 8'hB0); loadByte(8'h04, 8'hFF);   // JMP FF
      loadByte(8'hFF, 8'h10);                           // LDI R0,(00)
      releaseReset();
      applyStimulus(8);                                  // cycle 9
      checkOutput("wrap_opcode_fetch", 32'(mem_if.IO_MEM_ADDR), 32'hFF);
      applyStimulus(1);                                  // cycle 10
      checkOutput("wrap_operand_addr", 32'(mem_if.IO_MEM_ADDR), 32'h00);
      applyStimulus(2);                                  // cycle 12
      checkOutput("wrap_next_fetch", 32'(mem_if.IO_MEM_ADDR), 32'h01);
      applyStimulus(3);                                  // cycle 15
      checkOutput("wrap_ldi_mem85", 32'(mem[8'h85]), 32'h42);

      // ---------------- Opcode F --------------------------------------------
      startProgram();
      loadByte(8'h00, 8'h10); loadByte(8'h01, 8'h07);   // LDI R0,07
      loadByte(8'h02, 8'hF0);                           // HALT / NOP
      loadByte(8'h03, 8'h30); loadByte(8'h04, 8'h86);   // ST R0,86
      loadByte(8'h86, 8'hAA);
      releaseReset();
      applyStimulus(4);                                  // cycle 5: F0 exec
      checkOutput("f0_exec_halted", 32'(halted), 32'h0);
      applyStimulus(1);                                  // cycle 6
`ifdef BLACK_BEAN_HALT_EN
      checkOutput("halt_flag", 32'(halted), 32'h1);
      checkOutput("halt_addr", 32'(mem_if.IO_MEM_ADDR), 32'h03);
      checkOutput("halt_ren", 32'(mem_if.IO_MEM_R_EN), 32'h0);
      halt_addr = mem_if.IO_MEM_ADDR;
      rd_base   = rd_cnt;
      wr_base   = wr_cnt;
      applyStimulus(100);
      checkOutput("halt_addr_frozen", 32'(mem_if.IO_MEM_ADDR), 32'(halt_addr));
      checkOutput("halt_no_reads", 32'(rd_cnt - rd_base), 32'd0);
      checkOutput("halt_no_writes", 32'(wr_cnt - wr_base), 32'd0);
      checkOutput("halt_still", 32'(halted), 32'h1);
      checkOutput("halt_mem86_untouched", 32'(mem[8'h86]), 32'hAA);
`else
      checkOutput("f0_nop_fetch", 32'(mem_if.IO_MEM_ADDR), 32'h03);
      checkOutput("f0_nop_ren", 32'(mem_if.IO_MEM_R_EN), 32'h1);
      checkOutput("f0_nop_halted", 32'(halted), 32'h0);
      applyStimulus(3);                                  // cycle 9
      checkOutput("f0_nop_mem86", 32'(mem[8'h86]), 32'h07);
`endif

      // ---------------- Reset mid-instruction aborts the store --------------
      startProgram();
      loadByte(8'h00, 8'h30); loadByte(8'h01, 8'h87);   // ST R0,87
      loadByte(8'h87, 8'hAA);
      releaseReset();
      applyStimulus(1);                                  // cycle 2: operand
      rst = 1'b1;
      #1;
      checkOutput("abort_wen", 32'(mem_if.IO_MEM_W_EN), 32'h0);
      checkOutput("abort_addr", 32'(mem_if.IO_MEM_ADDR), 32'h00);
      applyStimulus(3);
      checkOutput("abort_mem87", 32'(mem[8'h87]), 32'hAA);
      checkOutput("abort_no_write", 32'(wr_cnt - wr_base), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/black_bean_core.md
Name: black_bean_core

Overview:
- Minimal 8-bit multi-cycle accumulator/register CPU; the top-level processing element of the black_bean design.
- Fetches instructions from, and loads/stores data to, one unified external memory through a single address/data port.
- Memory contract: combinational read of `IO_MEM_R_DATA` from `IO_MEM_ADDR`; synchronous write on `clk` rising edge when `IO_MEM_W_EN` = 1.
- After reset, execution starts at address `RESET_PC`, running the program preloaded into memory.

Parameters:
- `DATA_WIDTH`, 8: data, address and register width.
- `RESET_PC`, 8'h00: program counter value after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `IO_MEM_R_DATA`  in  8  memory read data, valid in the same cycle as `IO_MEM_ADDR`.
- `IO_MEM_W_DATA`  out  8  store data.
- `IO_MEM_ADDR`  out  8  memory address.
- `IO_MEM_R_EN`  out  1  high in cycles that sample `IO_MEM_R_DATA` (informational).
- `IO_MEM_W_EN`  out  1  memory write strobe, one cycle per store.
- `o_halted`  out  1  core stopped.

Behaviour:
- **Architectural state:** PC[7:0]; R0–R3 (8 bits each); IR[7:0]; OPR[7:0]; flags Z and C.
- **Reset:** PC = `RESET_PC`; R0–R3, IR, OPR, Z, C = 0; state = FETCH.
  - While reset is asserted: `IO_MEM_ADDR` = `RESET_PC`, `IO_MEM_R_EN` = 1, `IO_MEM_W_EN` = 0, `IO_MEM_W_DATA` = 0, `o_halted` = 0.
  - Reset mid-instruction aborts it; no write strobe is issued.
- **Instruction byte format:** [7:4] op, [3:2] rd, [1:0] rs.
- **Two-byte ops** (second byte = imm/addr): LDI, LD, ST, JMP, JZ, JC.
- **Opcodes:**
  - 0 NOP.
  - 1 LDI: rd = imm.
  - 2 LD: rd = mem[addr].
  - 3 ST: mem[addr] = rd.
  - 4 MOV: rd = rs.
  - 5 ADD: rd = rd + rs; C = carry-out.
  - 6 SUB: rd = rd − rs; C = borrow.
  - 7 AND, 8 OR, 9 XOR: rd = rd op rs; C = 0.
  - A NOT: rd = ~rd; C = 0.
  - B JMP: PC = addr.
  - C JZ: branch if Z = 1.
  - D JC: branch if C = 1.
  - E: reserved, executes as NOP.
  - F: HALT.
- **Flags:** Z is updated on ALU ops 5–A only (Z = result == 0). LDI, LD and MOV do not change flags.
- **State FETCH:** `IO_MEM_ADDR` = PC, `IO_MEM_R_EN` = 1. On the clock edge: IR ← `IO_MEM_R_DATA`, PC ← PC+1. Next state is OPERAND for two-byte ops, otherwise EXEC.
- **State OPERAND:** `IO_MEM_ADDR` = PC, `IO_MEM_R_EN` = 1. On the clock edge: OPR ← `IO_MEM_R_DATA`, PC ← PC+1. Next state EXEC.
- **State EXEC:**
  - LD: `IO_MEM_ADDR` = OPR, `IO_MEM_R_EN` = 1; rd ← data at the edge.
  - ST: `IO_MEM_ADDR` = OPR, `IO_MEM_W_DATA` = rd, `IO_MEM_W_EN` = 1 for exactly this cycle.
  - Other ops: `IO_MEM_ADDR` = PC, `IO_MEM_R_EN` = 0.
  - Next state is FETCH, or HALT for op F.
- **State HALT:** terminal until reset. `o_halted` = 1, `IO_MEM_ADDR` = PC, both enables = 0.
- **Latency:** one-byte ops take 2 cycles; two-byte ops take 3 cycles. The first fetch occurs in the first cycle after reset deasserts.
- **Wrap-around:** PC increments modulo 256 (0xFF → 0x00), including mid-instruction (operand fetched from 0x00).
- **Outputs:** all memory outputs are combinational from state/registers; no glitching requirement beyond synchronous design.
- **Self-modifying code:** a store to an address not yet fetched is seen by the later fetch.

Optional Feature:
- Macro `BLACK_BEAN_HALT_EN`.
- Defined: op F enters HALT as specified.
- Undefined: op F executes as a one-byte NOP, HALT state is not built, and `o_halted` is tied to 0.

Decomposition:
- **Shared package/define:** `DATA_WIDTH`; opcode constants OP_NOP … OP_HALT; state encoding FETCH/OPERAND/EXEC/HALT; register-index width (2).
- **Sub-module `black_bean_alu`:** combinational. Inputs: op, a, b. Outputs: result, carry, zero. Covers ops 4–A.
- **Top:** holds the FSM, PC, register file and memory-port muxing.

Test Plan:
- Reset/first fetch: hold `rst` = 1 for 2 cycles, then release. `IO_MEM_ADDR` = 00 and `IO_MEM_W_EN` = 0 during reset; first fetch at 00 in the cycle after release.
- LDI/ADD/ST:
  - Program: LDI R0,0x05; LDI R1,0xFB; ADD R0,R1; ST R0,0x80.
  - Expected: mem[80] = 0x00, Z = 1, C = 1.
  - Exactly one `IO_MEM_W_EN` pulse, with `IO_MEM_ADDR` = 80.
- LD/SUB borrow: mem[90] = 0x03. LD R2,0x90; LDI R3,0x04; SUB R2,R3; ST R2,0x91 → mem[91] = 0xFF, C = 1, Z = 0.
- Branches:
  - JZ not taken (Z = 0) continues at PC+2.
  - JZ taken after XOR R0,R0 jumps to the target.
  - JMP 0x10 → next fetch at 0x10.
  - JC taken after an overflowing ADD.
- PC wrap: place LDI R0,0x42 with the opcode at 0xFF and the operand at 0x00 → R0 = 0x42, next fetch at 0x01.
- HALT (`BLACK_BEAN_HALT_EN` defined): op F0 → `o_halted` = 1 after 2 cycles, address frozen, no further reads or writes for 100 cycles. Without the macro, F0 behaves as NOP.
